// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART core.
// Parity encodings, tick counts per frame segment and the TX/RX state enums.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } txState_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rxState_t;

    localparam int TICKS_BIT      = 16;
    localparam int TICKS_STOP1    = 16;
    localparam int TICKS_STOP2    = 32;
    localparam int TICK_MID_START = 7;

    function automatic logic parityEnabled(input parity_t p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo_lvl.sv
// First-word fall-through FIFO with an exact registered occupancy level.
// Data output reads 0 while empty.
module uart_fifo_lvl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [WIDTH-1:0]  i_w_data,
    output logic [WIDTH-1:0]  o_r_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_level;
    logic              w_doWr;
    logic              w_doRd;

    assign o_empty  = (r_level == '0);
    assign o_full   = (r_level == (ADDR_W+1)'(DEPTH));
    assign o_level  = r_level;
    assign o_r_data = o_empty ? '0 : r_mem[r_rdPtr];

    // A read frees a slot in the same cycle, so full+rd+wr performs both.
    assign w_doRd = i_rd && !o_empty;
    assign w_doWr = i_wr && (!o_full || w_doRd);

    always_ff @(posedge i_clk) begin
        if (w_doWr) begin
            r_mem[r_wrPtr] <= i_w_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doWr) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_doRd) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
            case ({w_doWr, w_doRd})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_core_cfg.sv
// Runtime-configurable UART core: baud generator, TX/RX FSMs and two level FIFOs.
// Optional internal loopback (i_loopback port) is enabled by defining UART_LOOPBACK_EN.
module uart_core_cfg
    import uart_pkg::*;
#(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 4,
    parameter int DVSR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DVSR_W-1:0] i_dvsr,
    input  logic [1:0]        i_parity,
    input  logic              i_stop2,
    input  logic              i_wr_uart,
    input  logic [DBIT-1:0]   i_w_data,
    input  logic              i_rd_uart,
    input  logic              i_clr_err,
    input  logic              i_rx,
`ifdef UART_LOOPBACK_EN
    input  logic              i_loopback,
`endif
    output logic              o_tx,
    output logic              o_tx_full,
    output logic [FIFO_W:0]   o_tx_level,
    output logic              o_rx_empty,
    output logic [FIFO_W:0]   o_rx_level,
    output logic [DBIT-1:0]   o_r_data,
    output logic              o_r_perr,
    output logic              o_r_ferr,
    output logic              o_rx_overrun,
    output logic              o_tx_done_tick,
    output logic              o_rx_done_tick
);

    localparam int BIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic [DVSR_W-1:0] r_dvsr;
    logic [DVSR_W-1:0] r_baudCnt;
    logic [DVSR_W-1:0] w_dvsrEff;
    logic              w_tick;

    txState_t          r_txState, w_txStateNext;
    logic [4:0]        r_txTicks, w_txTicksNext;
    logic [BIT_W-1:0]  r_txBitIdx, w_txBitIdxNext;
    logic [DBIT-1:0]   r_txShift, w_txShiftNext;
    parity_t           r_txParity, w_txParityNext;
    logic              r_txParBit, w_txParBitNext;
    logic              r_txStop2, w_txStop2Next;
    logic              r_txReg, w_txNext;
    logic              r_txDone, w_txDoneNext;
    logic              w_txPop;
    logic              w_txEmpty;
    logic [DBIT-1:0]   w_txHead;
    logic [4:0]        w_txStopLast;

    logic              r_rxSync1, r_rxSync2, r_rxPrev;
    logic              w_rxIn;
    rxState_t          r_rxState, w_rxStateNext;
    logic [4:0]        r_rxTicks, w_rxTicksNext;
    logic [BIT_W-1:0]  r_rxBitIdx, w_rxBitIdxNext;
    logic [DBIT-1:0]   r_rxShift, w_rxShiftNext;
    parity_t           r_rxParity, w_rxParityNext;
    logic              r_rxStop2, w_rxStop2Next;
    logic              r_rxPerr, w_rxPerrNext;
    logic              r_rxFerr, w_rxFerrNext;
    logic              r_rxDone;
    logic              w_rxWr;
    logic              w_rxFull;
    logic              w_rxDrop;
    logic              r_overrun;
    logic [DBIT+1:0]   w_rxHead;
    logic [4:0]        w_rxStopLast;

    // The divisor is only picked up while both directions are idle.
    assign w_dvsrEff = (r_dvsr == '0) ? DVSR_W'(1) : r_dvsr;
    assign w_tick    = (r_baudCnt >= w_dvsrEff - DVSR_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dvsr    <= '0;
            r_baudCnt <= '0;
        end else begin
            if (r_txState == TX_IDLE && r_rxState == RX_IDLE) begin
                r_dvsr <= i_dvsr;
            end
            r_baudCnt <= w_tick ? '0 : r_baudCnt + DVSR_W'(1);
        end
    end

    uart_fifo_lvl #(.WIDTH(DBIT), .ADDR_W(FIFO_W)) u_txFifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr     (i_wr_uart),
        .i_rd     (w_txPop),
        .i_w_data (i_w_data),
        .o_r_data (w_txHead),
        .o_full   (o_tx_full),
        .o_empty  (w_txEmpty),
        .o_level  (o_tx_level)
    );

    assign w_txStopLast = r_txStop2 ? 5'(TICKS_STOP2 - 1) : 5'(TICKS_STOP1 - 1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_txState  <= TX_IDLE;
            r_txTicks  <= '0;
            r_txBitIdx <= '0;
            r_txShift  <= '0;
            r_txParity <= PAR_NONE;
            r_txParBit <= 1'b0;
            r_txStop2  <= 1'b0;
            r_txReg    <= 1'b1;
            r_txDone   <= 1'b0;
        end else begin
            r_txState  <= w_txStateNext;
            r_txTicks  <= w_txTicksNext;
            r_txBitIdx <= w_txBitIdxNext;
            r_txShift  <= w_txShiftNext;
            r_txParity <= w_txParityNext;
            r_txParBit <= w_txParBitNext;
            r_txStop2  <= w_txStop2Next;
            r_txReg    <= w_txNext;
            r_txDone   <= w_txDoneNext;
        end
    end

    // The serial level is derived from the next state so o_tx changes with the state.
    always_comb begin
        w_txStateNext  = r_txState;
        w_txTicksNext  = r_txTicks;
        w_txBitIdxNext = r_txBitIdx;
        w_txShiftNext  = r_txShift;
        w_txParityNext = r_txParity;
        w_txParBitNext = r_txParBit;
        w_txStop2Next  = r_txStop2;
        w_txPop        = 1'b0;
        w_txDoneNext   = 1'b0;
        w_txNext       = 1'b1;
        case (r_txState)
            TX_IDLE: begin
                if (!w_txEmpty) begin
                    w_txPop        = 1'b1;
                    w_txShiftNext  = w_txHead;
                    w_txParityNext = parity_t'(i_parity);
                    w_txParBitNext = (parity_t'(i_parity) == PAR_ODD) ? ~^w_txHead : ^w_txHead;
                    w_txStop2Next  = i_stop2;
                    w_txTicksNext  = '0;
                    w_txStateNext  = TX_START;
                end
            end
            TX_START: begin
                if (w_tick) begin
                    if (r_txTicks == 5'(TICKS_BIT - 1)) begin
                        w_txTicksNext  = '0;
                        w_txBitIdxNext = '0;
                        w_txStateNext  = TX_DATA;
                    end else begin
                        w_txTicksNext = r_txTicks + 5'd1;
                    end
                end
            end
            TX_DATA: begin
                if (w_tick) begin
                    if (r_txTicks == 5'(TICKS_BIT - 1)) begin
                        w_txTicksNext = '0;
                        w_txShiftNext = r_txShift >> 1;
                        if (r_txBitIdx == BIT_W'(DBIT - 1)) begin
                            w_txStateNext = parityEnabled(r_txParity) ? TX_PARITY : TX_STOP;
                        end else begin
                            w_txBitIdxNext = r_txBitIdx + BIT_W'(1);
                        end
                    end else begin
                        w_txTicksNext = r_txTicks + 5'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (w_tick) begin
                    if (r_txTicks == 5'(TICKS_BIT - 1)) begin
                        w_txTicksNext = '0;
                        w_txStateNext = TX_STOP;
                    end else begin
                        w_txTicksNext = r_txTicks + 5'd1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tick) begin
                    if (r_txTicks == w_txStopLast) begin
                        w_txTicksNext = '0;
                        w_txDoneNext  = 1'b1;
                        w_txStateNext = TX_IDLE;
                    end else begin
                        w_txTicksNext = r_txTicks + 5'd1;
                    end
                end
            end
            default: w_txStateNext = TX_IDLE;
        endcase
        case (w_txStateNext)
            TX_START:  w_txNext = 1'b0;
            TX_DATA:   w_txNext = w_txShiftNext[0];
            TX_PARITY: w_txNext = w_txParBitNext;
            default:   w_txNext = 1'b1;
        endcase
    end

`ifdef UART_LOOPBACK_EN
    assign w_rxIn = i_loopback ? r_txReg : r_rxSync2;
    assign o_tx   = i_loopback ? 1'b1 : r_txReg;
`else
    assign w_rxIn = r_rxSync2;
    assign o_tx   = r_txReg;
`endif
    assign o_tx_done_tick = r_txDone;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= i_rx;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= w_rxIn;
        end
    end

    assign w_rxStopLast = r_rxStop2 ? 5'(TICKS_STOP2 - 1) : 5'(TICKS_STOP1 - 1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rxState  <= RX_IDLE;
            r_rxTicks  <= '0;
            r_rxBitIdx <= '0;
            r_rxShift  <= '0;
            r_rxParity <= PAR_NONE;
            r_rxStop2  <= 1'b0;
            r_rxPerr   <= 1'b0;
            r_rxFerr   <= 1'b0;
            r_rxDone   <= 1'b0;
        end else begin
            r_rxState  <= w_rxStateNext;
            r_rxTicks  <= w_rxTicksNext;
            r_rxBitIdx <= w_rxBitIdxNext;
            r_rxShift  <= w_rxShiftNext;
            r_rxParity <= w_rxParityNext;
            r_rxStop2  <= w_rxStop2Next;
            r_rxPerr   <= w_rxPerrNext;
            r_rxFerr   <= w_rxFerrNext;
            r_rxDone   <= w_rxWr;
        end
    end

    // Bits are sampled mid-slot: 8 ticks into the start bit, then every 16 ticks.
    always_comb begin
        w_rxStateNext  = r_rxState;
        w_rxTicksNext  = r_rxTicks;
        w_rxBitIdxNext = r_rxBitIdx;
        w_rxShiftNext  = r_rxShift;
        w_rxParityNext = r_rxParity;
        w_rxStop2Next  = r_rxStop2;
        w_rxPerrNext   = r_rxPerr;
        w_rxFerrNext   = r_rxFerr;
        w_rxWr         = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                if (r_rxPrev && !w_rxIn) begin
                    w_rxTicksNext  = '0;
                    w_rxParityNext = parity_t'(i_parity);
                    w_rxStop2Next  = i_stop2;
                    w_rxPerrNext   = 1'b0;
                    w_rxFerrNext   = 1'b0;
                    w_rxStateNext  = RX_START;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (r_rxTicks == 5'(TICK_MID_START)) begin
                        w_rxTicksNext  = '0;
                        w_rxBitIdxNext = '0;
                        w_rxStateNext  = w_rxIn ? RX_IDLE : RX_DATA;
                    end else begin
                        w_rxTicksNext = r_rxTicks + 5'd1;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    if (r_rxTicks == 5'(TICKS_BIT - 1)) begin
                        w_rxTicksNext = '0;
                        w_rxShiftNext = {w_rxIn, r_rxShift[DBIT-1:1]};
                        if (r_rxBitIdx == BIT_W'(DBIT - 1)) begin
                            w_rxStateNext = parityEnabled(r_rxParity) ? RX_PARITY : RX_STOP;
                        end else begin
                            w_rxBitIdxNext = r_rxBitIdx + BIT_W'(1);
                        end
                    end else begin
                        w_rxTicksNext = r_rxTicks + 5'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (w_tick) begin
                    if (r_rxTicks == 5'(TICKS_BIT - 1)) begin
                        w_rxTicksNext = '0;
                        w_rxPerrNext  = w_rxIn != ((r_rxParity == PAR_ODD) ? ~^r_rxShift : ^r_rxShift);
                        w_rxStateNext = RX_STOP;
                    end else begin
                        w_rxTicksNext = r_rxTicks + 5'd1;
                    end
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    if (r_rxTicks == 5'(TICKS_BIT - 1)) begin
                        w_rxFerrNext = !w_rxIn;
                    end
                    if (r_rxTicks == w_rxStopLast) begin
                        w_rxTicksNext = '0;
                        w_rxWr        = 1'b1;
                        w_rxStateNext = RX_IDLE;
                    end else begin
                        w_rxTicksNext = r_rxTicks + 5'd1;
                    end
                end
            end
            default: w_rxStateNext = RX_IDLE;
        endcase
    end

    uart_fifo_lvl #(.WIDTH(DBIT + 2), .ADDR_W(FIFO_W)) u_rxFifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_wr     (w_rxWr),
        .i_rd     (i_rd_uart),
        .i_w_data ({w_rxFerrNext, r_rxPerr, r_rxShift}),
        .o_r_data (w_rxHead),
        .o_full   (w_rxFull),
        .o_empty  (o_rx_empty),
        .o_level  (o_rx_level)
    );

    // A simultaneous pop makes room, so only an unserviced full FIFO drops the byte.
    assign w_rxDrop = w_rxWr && w_rxFull && !i_rd_uart;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overrun <= 1'b0;
        end else if (w_rxDrop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_err) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_r_data       = w_rxHead[DBIT-1:0];
    assign o_r_perr       = w_rxHead[DBIT];
    assign o_r_ferr       = w_rxHead[DBIT+1];
    assign o_rx_overrun   = r_overrun;
    assign o_rx_done_tick = r_rxDone;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Self-checking bench for uart_core_cfg: table-driven RX frames, TX waveform checks,
// external loopback, overrun, false start and mid-frame reset.
module tb_uart_core_cfg;

    typedef struct {
        logic [7:0] data;
        logic [1:0] parity;
        logic       stop2;
        logic       flipPar;
        logic       badStop;
        logic       expPerr;
        logic       expFerr;
    } rxVec_t;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rxExp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dvsr;
    logic [1:0]  parity;
    logic        stop2;
    logic        wrUart;
    logic [7:0]  wData;
    logic        rdUart;
    logic        clrErr;
    logic        rxDrive;
    logic        loopMode;
    logic        rxLine;
    logic        txLine;
    logic        txFull;
    logic [4:0]  txLevel;
    logic        rxEmpty;
    logic [4:0]  rxLevel;
    logic [7:0]  rData;
    logic        rPerr;
    logic        rFerr;
    logic        rxOverrun;
    logic        txDoneTick;
    logic        rxDoneTick;

    int          tests = 0;
    int          errors = 0;
    int          bitClks = 48;
    int          rxDoneCount = 0;
    int          txDoneCount = 0;
    logic        overrunAtDone = 1'b0;
    logic        captureRuns = 1'b0;
    logic        prevTx = 1'b1;
    int          runLen = 0;
    int          txRuns[$];
    int          expRuns[6] = '{48, 48, 48, 96, 48, 48};
    rxExp_t      sbQ[$];
    rxVec_t      vecs[7];
    int          prevCount;

    assign rxLine = loopMode ? txLine : rxDrive;

    uart_core_cfg #(.DBIT(8), .FIFO_W(4), .DVSR_W(16)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_dvsr         (dvsr),
        .i_parity       (parity),
        .i_stop2        (stop2),
        .i_wr_uart      (wrUart),
        .i_w_data       (wData),
        .i_rd_uart      (rdUart),
        .i_clr_err      (clrErr),
        .i_rx           (rxLine),
        .o_tx           (txLine),
        .o_tx_full      (txFull),
        .o_tx_level     (txLevel),
        .o_rx_empty     (rxEmpty),
        .o_rx_level     (rxLevel),
        .o_r_data       (rData),
        .o_r_perr       (rPerr),
        .o_r_ferr       (rFerr),
        .o_rx_overrun   (rxOverrun),
        .o_tx_done_tick (txDoneTick),
        .o_rx_done_tick (rxDoneTick)
    );

    always #5 clk = ~clk;

    // Event counters and TX run-length capture, sampled away from the active edge.
    always @(negedge clk) begin
        if (rxDoneTick) begin
            rxDoneCount++;
            overrunAtDone = rxOverrun;
        end
        if (txDoneTick) begin
            txDoneCount++;
        end
        if (captureRuns) begin
            if (txLine !== prevTx) begin
                txRuns.push_back(runLen);
                runLen = 1;
            end else begin
                runLen++;
            end
        end
        prevTx = txLine;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyConfig(input logic [15:0] d, input logic [1:0] p, input logic s);
        dvsr    = d;
        parity  = p;
        stop2   = s;
        bitClks = 16 * int'(d);
        repeat (4) @(negedge clk);
    endtask

    task automatic driveBit(input logic b);
        rxDrive = b;
        repeat (bitClks) @(negedge clk);
    endtask

    task automatic driveRxFrame(input logic [7:0] d, input logic [1:0] p, input logic s,
                                input logic flipPar, input logic badStop);
        logic parBit;
        driveBit(1'b0);
        for (int k = 0; k < 8; k++) begin
            driveBit(d[k]);
        end
        if (p == 2'b01 || p == 2'b10) begin
            parBit = (p == 2'b10) ? ~^d : ^d;
            driveBit(parBit ^ flipPar);
        end
        driveBit(!badStop);
        if (s) begin
            driveBit(1'b1);
        end
        driveBit(1'b1);
    endtask

    task automatic applyStimulus(input rxVec_t v);
        applyConfig(16'd3, v.parity, v.stop2);
        sbQ.push_back(rxExp_t'({v.expFerr, v.expPerr, v.data}));
        driveRxFrame(v.data, v.parity, v.stop2, v.flipPar, v.badStop);
    endtask

    task automatic writeTx(input logic [7:0] b);
        wData  = b;
        wrUart = 1'b1;
        @(negedge clk);
        wrUart = 1'b0;
    endtask

    task automatic drainRx(input string tag);
        rxExp_t e;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({tag, "_notempty"}, 32'(rxEmpty), 0);
            checkOutput({tag, "_data"}, 32'(rData), 32'(e.data));
            checkOutput({tag, "_perr"}, 32'(rPerr), 32'(e.perr));
            checkOutput({tag, "_ferr"}, 32'(rFerr), 32'(e.ferr));
            rdUart = 1'b1;
            @(negedge clk);
            rdUart = 1'b0;
        end
        checkOutput({tag, "_empty_after"}, 32'(rxEmpty), 1);
    endtask

    task automatic sampleTxFrame(input string tag, input int nSlots, input logic [15:0] expBits);
        int waitCnt;
        waitCnt = 0;
        while (txLine !== 1'b0 && waitCnt < 1000) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({tag, "_start_seen"}, 32'(waitCnt < 1000), 1);
        repeat (bitClks / 2) @(negedge clk);
        for (int k = 0; k < nSlots; k++) begin
            checkOutput($sformatf("%s_slot%0d", tag, k), 32'(txLine), 32'(expBits[k]));
            repeat (bitClks) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; dvsr = 16'd3; parity = 2'b00; stop2 = 1'b0;
        wrUart = 1'b0; wData = 8'h00; rdUart = 1'b0; clrErr = 1'b0;
        rxDrive = 1'b1; loopMode = 1'b0;

        vecs[0] = '{8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h07, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'hC3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (5) @(negedge clk);
        checkOutput("rst_tx", 32'(txLine), 1);
        checkOutput("rst_tx_full", 32'(txFull), 0);
        checkOutput("rst_tx_level", 32'(txLevel), 0);
        checkOutput("rst_rx_empty", 32'(rxEmpty), 1);
        checkOutput("rst_rx_level", 32'(rxLevel), 0);
        checkOutput("rst_r_data", 32'(rData), 0);
        checkOutput("rst_perr", 32'(rPerr), 0);
        checkOutput("rst_ferr", 32'(rFerr), 0);
        checkOutput("rst_overrun", 32'(rxOverrun), 0);
        checkOutput("rst_tx_done", 32'(txDoneTick), 0);
        checkOutput("rst_rx_done", 32'(rxDoneTick), 0);
        reset = 1'b0;
        applyConfig(16'd3, 2'b00, 1'b0);

        // 8N1 transmit of 0xA5 with run-length capture
        txRuns.delete();
        runLen      = 0;
        captureRuns = 1'b1;
        prevCount   = txDoneCount;
        writeTx(8'hA5);
        sampleTxFrame("tx_a5", 10, 16'h034A);
        repeat (bitClks) @(negedge clk);
        captureRuns = 1'b0;
        checkOutput("tx_a5_done_ticks", 32'(txDoneCount - prevCount), 1);
        if (txRuns.size() < 8) begin
            checkOutput("tx_a5_run_count", 32'(txRuns.size()), 8);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checkOutput($sformatf("tx_a5_run%0d", k + 2), 32'(txRuns[k + 2]), 32'(expRuns[k]));
            end
        end

        // External loopback with even parity
        loopMode = 1'b1;
        applyConfig(16'd3, 2'b01, 1'b0);
        sbQ.push_back(rxExp_t'({1'b0, 1'b0, 8'h07}));
        writeTx(8'h07);
        sampleTxFrame("lb", 11, 16'h060E);
        repeat (bitClks) @(negedge clk);
        drainRx("lb_rx");
        loopMode = 1'b0;

        // Table-driven receive vectors
        for (int i = 0; i < 7; i++) begin
            prevCount = rxDoneCount;
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_done", i), 32'(rxDoneCount - prevCount), 1);
            drainRx($sformatf("vec%0d", i));
        end

        // Fill the RX FIFO and overflow it by one
        applyConfig(16'd3, 2'b00, 1'b0);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                sbQ.push_back(rxExp_t'({1'b0, 1'b0, 8'(i * 37 + 11)}));
            end
            driveRxFrame(8'(i * 37 + 11), 2'b00, 1'b0, 1'b0, 1'b0);
            if (i == 15) begin
                checkOutput("ovr_level_at_16", 32'(rxLevel), 16);
                checkOutput("ovr_flag_before", 32'(rxOverrun), 0);
            end
        end
        checkOutput("ovr_level", 32'(rxLevel), 16);
        checkOutput("ovr_flag", 32'(rxOverrun), 1);
        clrErr = 1'b1;
        @(negedge clk);
        clrErr = 1'b0;
        @(negedge clk);
        checkOutput("ovr_cleared", 32'(rxOverrun), 0);
        clrErr = 1'b1;
        driveRxFrame(8'hEE, 2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_set_beats_clear", 32'(overrunAtDone), 1);
        clrErr = 1'b0;
        @(negedge clk);
        checkOutput("ovr_cleared_again", 32'(rxOverrun), 0);
        checkOutput("ovr_level_kept", 32'(rxLevel), 16);
        drainRx("ovr");

        // Short low glitch must be rejected as a false start
        prevCount = rxDoneCount;
        rxDrive = 1'b0;
        repeat (4 * 3) @(negedge clk);
        rxDrive = 1'b1;
        repeat (2 * bitClks) @(negedge clk);
        checkOutput("glitch_no_done", 32'(rxDoneCount - prevCount), 0);
        checkOutput("glitch_level", 32'(rxLevel), 0);
        applyStimulus('{8'h3C, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        checkOutput("glitch_next_done", 32'(rxDoneCount - prevCount), 1);
        drainRx("glitch_after");

        // Reset in the middle of a TX data phase
        applyConfig(16'd3, 2'b00, 1'b0);
        writeTx(8'h00);
        writeTx(8'h00);
        writeTx(8'h00);
        repeat (2 * bitClks + 24) @(negedge clk);
        checkOutput("rstmid_tx_low", 32'(txLine), 0);
        checkOutput("rstmid_level", 32'(txLevel), 2);
        prevCount = txDoneCount;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_tx_high", 32'(txLine), 1);
        checkOutput("rstmid_tx_level0", 32'(txLevel), 0);
        checkOutput("rstmid_rx_level0", 32'(rxLevel), 0);
        reset = 1'b0;
        repeat (12 * bitClks) @(negedge clk);
        checkOutput("rstmid_idle", 32'(txLine), 1);
        checkOutput("rstmid_no_done", 32'(txDoneCount - prevCount), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
